// File: rtl/leve1_if_if.sv
// Bundle between the LEVE1 fetch stage, instruction memory and decode.
// master = fetch stage (leve1_if), slave = memory/decode/redirect side.
interface leve1_if_if #(
    parameter int XLEN = 32
);
    logic            IMEM_REQ_VALID;
    logic            IMEM_REQ_READY;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_RSP_VALID;
    logic [31:0]     IMEM_RSP_DATA;
    logic            OVALID;
    logic            OREADY;
    logic [XLEN-1:0] OPC;
    logic [31:0]     OINSTR;
    logic            IFLASH;
    logic [XLEN-1:0] IFLASH_PC;

    modport master (
        output IMEM_REQ_VALID, IMEM_ADDR, OVALID, OPC, OINSTR,
        input  IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, OREADY, IFLASH, IFLASH_PC
    );

    modport slave (
        input  IMEM_REQ_VALID, IMEM_ADDR, OVALID, OPC, OINSTR,
        output IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, OREADY, IFLASH, IFLASH_PC
    );
endinterface

// File: rtl/leve1_if.sv
// LEVE1 instruction-fetch stage: issues pipelined word fetches under a credit
// limit of DEPTH (outstanding + buffered), buffers returned words in an
// in-order FIFO for decode, and redirects/discards stale responses on IFLASH.
// Optional macro LEVE1_IF_BYPASS_EN: an empty FIFO forwards a fresh response
// straight to decode in the same cycle.
module leve1_if #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter int              DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    leve1_if_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rpc;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   disc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            issue;
    logic            rsp_ok;
    logic            rsp_keep;
    logic            bypass;
    logic            byp_take;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] flush_pc;

    // Circular pointer advance; DEPTH need not fill the pointer range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode, credit check and output selection.
    always_comb begin
        credit_used = {1'b0, outst} + {1'b0, count};
        req_valid   = !RST && !bus.IFLASH && (credit_used < (CW+1)'(DEPTH));
        issue       = req_valid && bus.IMEM_REQ_READY;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_ok      = bus.IMEM_RSP_VALID && (outst != '0);
        rsp_keep    = !RST && !bus.IFLASH && rsp_ok && (disc == '0);
        flush_pc    = bus.IFLASH_PC & ~XLEN'(3);
`ifdef LEVE1_IF_BYPASS_EN
        bypass      = rsp_keep && (count == '0);
        byp_take    = bypass && bus.OREADY;
        bus.OPC     = (count != '0) ? pc_mem[rd_ptr]    : rpc;
        bus.OINSTR  = (count != '0) ? instr_mem[rd_ptr] : bus.IMEM_RSP_DATA;
`else
        bypass      = 1'b0;
        byp_take    = 1'b0;
        bus.OPC     = pc_mem[rd_ptr];
        bus.OINSTR  = instr_mem[rd_ptr];
`endif
        push        = rsp_keep && !byp_take;
        pop         = !RST && !bus.IFLASH && (count != '0) && bus.OREADY;
        bus.IMEM_REQ_VALID = req_valid;
        bus.IMEM_ADDR      = fpc;
        bus.OVALID         = !RST && ((count != '0) || bypass);
    end

    // Control state: PCs, credit counters and FIFO pointers; flush overrides all.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc    <= RESET_VEC;
            rpc    <= RESET_VEC;
            outst  <= '0;
            disc   <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.IFLASH) begin
            fpc    <= flush_pc;
            rpc    <= flush_pc;
            outst  <= outst - CW'(rsp_ok);
            disc   <= outst - CW'(rsp_ok);
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue) begin
                fpc <= fpc + XLEN'(4);
            end
            outst <= outst + CW'(issue) - CW'(rsp_ok);
            if (rsp_ok && (disc != '0)) begin
                disc <= disc - CW'(1);
            end
            if (rsp_keep) begin
                rpc <= rpc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rpc;
            instr_mem[wr_ptr] <= bus.IMEM_RSP_DATA;
        end
    end

endmodule

// File: tb/tb_leve1_if.sv
// Directed bench for leve1_if (DEPTH=4): a behavioural memory with variable
// latency answers fetches with addr ^ KEY; the stimulus pushes the expected
// {pc, instr} stream into a queue and a negedge monitor checks every
// instruction accepted by decode against it.
module tb_leve1_if;

    localparam int          XLEN = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC = 32'h8000_0000;
    localparam logic [31:0] KEY  = 32'h1357_9BDF;
`ifdef LEVE1_IF_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    leve1_if_if #(.XLEN(XLEN)) bus ();

    leve1_if #(.XLEN(XLEN), .RESET_VEC(RVEC), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    lat = 1;
    int    cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = base + 32'(4 * i);
            e.instr = (base + 32'(4 * i)) ^ KEY;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Instruction memory: accepts on handshake, answers in order after lat cycles.
    initial begin
        logic        hs;
        logic [31:0] a;
        bus.IMEM_RSP_VALID = 1'b0;
        bus.IMEM_RSP_DATA  = '0;
        forever begin
            @(negedge clk);
            hs = bus.IMEM_REQ_VALID && bus.IMEM_REQ_READY;
            a  = bus.IMEM_ADDR;
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                mem_q.delete();
            end else if (hs) begin
                mreq_t m;
                m.addr = a;
                m.due  = cyc + lat - 1;
                mem_q.push_back(m);
            end
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                bus.IMEM_RSP_VALID = 1'b1;
                bus.IMEM_RSP_DATA  = mem_q[0].addr ^ KEY;
                void'(mem_q.pop_front());
            end else begin
                bus.IMEM_RSP_VALID = 1'b0;
                bus.IMEM_RSP_DATA  = '0;
            end
        end
    end

    // Monitor: every instruction decode accepts must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.OVALID && bus.OREADY && !bus.IFLASH) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", 64'(bus.OPC), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("opc", 64'(bus.OPC), 64'(e.pc));
                    check("oinstr", 64'(bus.OINSTR), 64'(e.instr));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        rst                = 1'b1;
        bus.IMEM_REQ_READY = 1'b1;
        bus.OREADY         = 1'b1;
        bus.IFLASH         = 1'b0;
        bus.IFLASH_PC      = '0;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ovalid", 64'(bus.OVALID), 64'd0);
            check("rst_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd0);
        end
        check("rst_count", 64'(dut.count), 64'd0);
        check("rst_outst", 64'(dut.outst), 64'd0);

        // Stream from reset vector
        push_exp(RVEC, 6);
        rst = 1'b0;
        #1;
        check("first_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd1);
        check("first_req_addr", 64'(bus.IMEM_ADDR), 64'(RVEC));
        wait_empty("stream_timeout", 60);
        bus.OREADY = 1'b0;

        // Backpressure: FIFO fills to DEPTH, requests stop
        repeat (10) tick();
        check("bp_count", 64'(dut.count), 64'(DEPTH));
        check("bp_outst", 64'(dut.outst), 64'd0);
        check("bp_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd0);
        check("bp_ovalid", 64'(bus.OVALID), 64'd1);
        push_exp(RVEC + 32'd24, 6);
        bus.OREADY = 1'b1;
        wait_empty("drain_timeout", 60);
        bus.OREADY = 1'b0;

        // Memory stall after a redirect: address held, outst unchanged
        bus.IMEM_REQ_READY = 1'b0;
        repeat (3) tick();
        bus.IFLASH    = 1'b1;
        bus.IFLASH_PC = 32'h0000_0300;
        tick();
        bus.IFLASH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_addr", 64'(bus.IMEM_ADDR), 64'h300);
            check("stall_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd1);
            check("stall_outst", 64'(dut.outst), 64'd0);
            tick();
        end
        push_exp(32'h0000_0300, 4);
        bus.IMEM_REQ_READY = 1'b1;
        bus.OREADY         = 1'b1;
        wait_empty("stall_resume_timeout", 60);
        bus.OREADY = 1'b0;

        // Flush with 2 outstanding, 2-cycle memory
        repeat (6) tick();
        lat           = 2;
        bus.IFLASH    = 1'b1;
        bus.IFLASH_PC = 32'h0000_0400;
        tick();
        bus.IFLASH = 1'b0;
        for (int i = 0; i < 10 && dut.outst != 2; i++) tick();
        check("fl2_outst", 64'(dut.outst), 64'd2);
        check("fl2_rsp_valid", 64'(bus.IMEM_RSP_VALID), 64'd1);
        bus.IFLASH    = 1'b1;
        bus.IFLASH_PC = 32'h0000_0100;
        push_exp(32'h0000_0100, 4);
        tick();
        bus.IFLASH = 1'b0;
        #1;
        check("fl2_disc", 64'(dut.disc), 64'd1);
        check("fl2_outst_after", 64'(dut.outst), 64'd1);
        check("fl2_req_addr", 64'(bus.IMEM_ADDR), 64'h100);
        check("fl2_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd1);
        bus.OREADY = 1'b1;
        wait_empty("fl2_timeout", 60);
        bus.OREADY = 1'b0;

        // Flush coincident with a response and a pop, unaligned target
        repeat (6) tick();
        lat           = 1;
        push_exp(32'h0000_0500, 3);
        bus.OREADY    = 1'b1;
        bus.IFLASH    = 1'b1;
        bus.IFLASH_PC = 32'h0000_0500;
        tick();
        bus.IFLASH = 1'b0;
        wait_empty("fl3_pre_timeout", 30);
        check("fl3_ovalid_pre", 64'(bus.OVALID), 64'd1);
        check("fl3_rsp_pre", 64'(bus.IMEM_RSP_VALID), 64'd1);
        bus.IFLASH    = 1'b1;
        bus.IFLASH_PC = 32'h0000_0203;
        push_exp(32'h0000_0200, 4);
        tick();
        bus.IFLASH = 1'b0;
        #1;
        check("fl3_ovalid_next", 64'(bus.OVALID), 64'd0);
        check("fl3_req_addr", 64'(bus.IMEM_ADDR), 64'h200);
        check("fl3_req_valid", 64'(bus.IMEM_REQ_VALID), 64'd1);
        check("fl3_disc", 64'(dut.disc), 64'd0);
        tick();
        check("first_rsp_valid", 64'(bus.IMEM_RSP_VALID), 64'd1);
        check("first_rsp_ovalid", 64'(bus.OVALID), 64'(BYP));
        check("first_rsp_count", 64'(dut.count), 64'd0);
        tick();
        check("ovalid_after_rsp", 64'(bus.OVALID), 64'd1);
        wait_empty("fl3_timeout", 60);
        bus.OREADY = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
